// File: rtl/rv32i_core_pkg.sv
// Shared types for the RV32I core: pipeline-controller FSM states and per-stage control bundles.
package rv32i_core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/rv32i_dmem_seq.sv
// Single-outstanding data-memory sequencer: req/gnt/rvalid handshake, MEM-stage freeze and
// optional access timeout (TIMEOUT_CYCLES = 0 disables it).
module rv32i_dmem_seq
  import rv32i_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_access_i,
  input  logic mem_write_i,
  input  logic dmem_gnt_i,
  input  logic dmem_rvalid_i,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic mem_stall_o,
  output logic bus_err_o
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  pipe_ctrl_state_e state_q, state_d;
  logic             we_q, we_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             timeout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cnt_d       = '0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    mem_stall_o = 1'b0;
    bus_err_o   = 1'b0;
    // cnt_q holds the wait cycles already spent, so this is the TIMEOUT_CYCLES-th one
    timeout_hit = TO_EN && (state_q != RUN) && (cnt_q == TO_W'(TO_LAST));

    case (state_q)
      RUN: begin
        if (mem_access_i) begin
          dmem_req_o = 1'b1;
          dmem_we_o  = mem_write_i;
          we_d       = mem_write_i;
          if (dmem_gnt_i) begin
            if (!mem_write_i) state_d = MEM_RESP;
          end else begin
            state_d     = MEM_REQ;
            mem_stall_o = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = we_q;
        if (dmem_gnt_i) state_d = we_q ? RUN : MEM_RESP;
        else            mem_stall_o = 1'b1;
      end
      MEM_RESP: begin
        if (dmem_rvalid_i) state_d = RUN;
        else               mem_stall_o = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Abort: drop the request and release the pipeline in the same cycle
    if (timeout_hit) begin
      bus_err_o   = 1'b1;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      mem_stall_o = 1'b0;
      state_d     = RUN;
    end

    if (TO_EN && (state_q != RUN) && (state_d == state_q)) cnt_d = cnt_q + TO_W'(1);

    if (rst_i) begin
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      mem_stall_o = 1'b0;
      bus_err_o   = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stalls, flushes, PC redirect.
// Define RV32I_PIPE_CTRL_PERF_EN to add saturating stall/redirect performance counters.
module rv32i_pipe_ctrl
  import rv32i_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_branch_taken_i,
  input  logic [XLEN-1:0]   ex_branch_target_i,
  input  logic              mem_valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              bus_err_o
`ifdef RV32I_PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_mem_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_lu_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_flush_cnt_o
`endif
);

  logic        mem_access;
  logic        mem_stall;
  logic        load_use;
  logic        branch_take;
  stage_ctrl_t ctrl_id;
  stage_ctrl_t ctrl_ex;

  assign mem_access = mem_valid_i & (mem_read_i | mem_write_i);

  rv32i_dmem_seq #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dmem_seq (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_access_i (mem_access),
    .mem_write_i  (mem_write_i),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .mem_stall_o  (mem_stall),
    .bus_err_o    (bus_err_o)
  );

  always_comb begin
    load_use = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != '0) &
               ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
    branch_take = ex_branch_taken_i & ~mem_stall;
  end

  // Priority: reset > mem_stall > branch > load-use > run
  always_comb begin
    stall_if_o       = 1'b0;
    stall_mem_o      = 1'b0;
    ctrl_id          = '0;
    ctrl_ex          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (!rst_i) begin
      if (mem_stall) begin
        stall_if_o    = 1'b1;
        ctrl_id.stall = 1'b1;
        ctrl_ex.stall = 1'b1;
        stall_mem_o   = 1'b1;
      end else if (branch_take) begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = ex_branch_target_i;
        ctrl_id.flush    = 1'b1;
        ctrl_ex.flush    = 1'b1;
      end else if (load_use) begin
        stall_if_o    = 1'b1;
        ctrl_id.stall = 1'b1;
        ctrl_ex.flush = 1'b1;
      end
    end
  end

  assign stall_id_o = ctrl_id.stall;
  assign flush_id_o = ctrl_id.flush;
  assign stall_ex_o = ctrl_ex.stall;
  assign flush_ex_o = ctrl_ex.flush;

`ifdef RV32I_PIPE_CTRL_PERF_EN
  logic lu_stall_cycle;
  assign lu_stall_cycle = ~rst_i & load_use & ~mem_stall & ~branch_take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_mem_stall_cnt_o <= '0;
      perf_lu_stall_cnt_o  <= '0;
      perf_flush_cnt_o     <= '0;
    end else begin
      if (mem_stall && (perf_mem_stall_cnt_o != '1))
        perf_mem_stall_cnt_o <= perf_mem_stall_cnt_o + CNT_W'(1);
      if (lu_stall_cycle && (perf_lu_stall_cnt_o != '1))
        perf_lu_stall_cnt_o <= perf_lu_stall_cnt_o + CNT_W'(1);
      if (redirect_valid_o && (perf_flush_cnt_o != '1))
        perf_flush_cnt_o <= perf_flush_cnt_o + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the perf counters; this build has none.
  if (CNT_W == 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl (TIMEOUT_CYCLES=4): hazards, branches, dmem handshake, timeout, reset.
module tb_rv32i_pipe_ctrl;

  // ctl = {req, we, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, redirect_valid, bus_err}
  localparam logic [9:0] IDLE   = 10'b00_0000_0000;
  localparam logic [9:0] LU     = 10'b00_1100_0100;
  localparam logic [9:0] BR     = 10'b00_0000_1110;
  localparam logic [9:0] REQ_WT = 10'b10_1111_0000;
  localparam logic [9:0] RSP_WT = 10'b00_1111_0000;
  localparam logic [9:0] REQ_LD = 10'b10_0000_0000;
  localparam logic [9:0] REQ_ST = 10'b11_0000_0000;
  localparam logic [9:0] BERR   = 10'b00_0000_0001;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i, id_rs1_used_i, id_rs2_used_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        ex_valid_i, ex_mem_read_i, ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;
  logic        mem_valid_i, mem_read_i, mem_write_i;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        dmem_req_o, dmem_we_o;
  logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic        flush_id_o, flush_ex_o, redirect_valid_o, bus_err_o;
  logic [31:0] redirect_pc_o;
`ifdef RV32I_PIPE_CTRL_PERF_EN
  logic [31:0] perf_mem_stall_cnt_o, perf_lu_stall_cnt_o, perf_flush_cnt_o;
`endif

  logic [9:0] ctl;
  int checks = 0;
  int errors = 0;

  assign ctl = {dmem_req_o, dmem_we_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                flush_id_o, flush_ex_o, redirect_valid_o, bus_err_o};

  always #5 clk_i = ~clk_i;

  rv32i_pipe_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .ex_valid_i        (ex_valid_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_branch_target_i(ex_branch_target_i),
    .mem_valid_i       (mem_valid_i),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .stall_if_o        (stall_if_o),
    .stall_id_o        (stall_id_o),
    .stall_ex_o        (stall_ex_o),
    .stall_mem_o       (stall_mem_o),
    .flush_id_o        (flush_id_o),
    .flush_ex_o        (flush_ex_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .bus_err_o         (bus_err_o)
`ifdef RV32I_PIPE_CTRL_PERF_EN
    ,
    .perf_mem_stall_cnt_o(perf_mem_stall_cnt_o),
    .perf_lu_stall_cnt_o (perf_lu_stall_cnt_o),
    .perf_flush_cnt_o    (perf_flush_cnt_o)
`endif
  );

  task automatic idle();
    id_valid_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    ex_valid_i = 0; ex_rd_addr_i = 0; ex_mem_read_i = 0;
    ex_branch_taken_i = 0; ex_branch_target_i = 0;
    mem_valid_i = 0; mem_read_i = 0; mem_write_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0;
  endtask

  // EX: lw x<rd>; ID reads rs1/rs2
  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    id_valid_i = 1; ex_valid_i = 1; ex_mem_read_i = 1; ex_rd_addr_i = rd;
    id_rs1_addr_i = rs1; id_rs1_used_i = u1;
    id_rs2_addr_i = rs2; id_rs2_used_i = u2;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge
  task automatic chk(input string tag, input logic [9:0] exp_ctl, input logic [31:0] exp_pc);
    @(negedge clk_i);
    checks++;
    assert (ctl === exp_ctl && redirect_pc_o === exp_pc) else begin
      errors++;
      $error("FAIL %s: observed ctl=%b pc=%h expected ctl=%b pc=%h",
             tag, ctl, redirect_pc_o, exp_ctl, exp_pc);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    idle();
    rst_i = 1;
    // Everything active during reset must still yield all-zero outputs
    mem_valid_i = 1; mem_read_i = 1;
    set_lu(5'd5, 5'd5, 1, 5'd1, 1);
    ex_branch_taken_i = 1; ex_branch_target_i = 32'h100;
    chk("reset_gated", IDLE, 32'h0);
    chk("reset_hold", IDLE, 32'h0);
    idle();
    rst_i = 0;
    chk("post_reset", IDLE, 32'h0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    set_lu(5'd5, 5'd5, 1, 5'd1, 1);
    chk("lu_rs1", LU, 32'h0);
    ex_mem_read_i = 0; ex_rd_addr_i = 5'd6;
    chk("lu_next_clean", IDLE, 32'h0);
    set_lu(5'd7, 5'd2, 1, 5'd7, 1);
    chk("lu_rs2", LU, 32'h0);
    set_lu(5'd0, 5'd0, 1, 5'd0, 1);
    chk("lu_rd_x0", IDLE, 32'h0);
    set_lu(5'd9, 5'd9, 0, 5'd3, 1);
    chk("lu_rs1_unused", IDLE, 32'h0);
    idle();

    // Taken branch coincident with load-use
    set_lu(5'd5, 5'd5, 1, 5'd1, 1);
    ex_branch_taken_i = 1; ex_branch_target_i = 32'h0000_0100;
    chk("branch_over_lu", BR, 32'h100);
    ex_branch_taken_i = 0;
    id_valid_i = 0;
    chk("branch_pc_zeroed", IDLE, 32'h0);
    idle();

    // Load: gnt after 3 cycles, rvalid after 2 wait cycles in MEM_RESP
    mem_valid_i = 1; mem_read_i = 1;
    chk("ld_run_wait", REQ_WT, 32'h0);
    chk("ld_req_wait1", REQ_WT, 32'h0);
    chk("ld_req_wait2", REQ_WT, 32'h0);
    dmem_gnt_i = 1;
    chk("ld_gnt", REQ_LD, 32'h0);
    dmem_gnt_i = 0;
    chk("ld_resp_wait1", RSP_WT, 32'h0);
    chk("ld_resp_wait2", RSP_WT, 32'h0);
    dmem_rvalid_i = 1;
    chk("ld_rvalid_release", IDLE, 32'h0);
    idle();
    chk("ld_done", IDLE, 32'h0);

    // Store granted immediately: zero stall
    mem_valid_i = 1; mem_write_i = 1; dmem_gnt_i = 1;
    chk("st_zero_cycle", REQ_ST, 32'h0);
    idle();
    chk("st_done", IDLE, 32'h0);

    // Branch in EX while the MEM load waits for rvalid
    mem_valid_i = 1; mem_read_i = 1; dmem_gnt_i = 1;
    chk("br_ld_gnt", REQ_LD, 32'h0);
    dmem_gnt_i = 0;
    ex_valid_i = 1; ex_branch_taken_i = 1; ex_branch_target_i = 32'h0000_0200;
    chk("br_frozen1", RSP_WT, 32'h0);
    chk("br_frozen2", RSP_WT, 32'h0);
    dmem_rvalid_i = 1;
    chk("br_release", BR, 32'h200);
    idle();
    chk("br_once", IDLE, 32'h0);

    // Timeout: gnt never arrives
    mem_valid_i = 1; mem_read_i = 1;
    chk("to_run", REQ_WT, 32'h0);
    chk("to_req1", REQ_WT, 32'h0);
    chk("to_req2", REQ_WT, 32'h0);
    chk("to_req3", REQ_WT, 32'h0);
    chk("to_bus_err", BERR, 32'h0);
    idle();
    dmem_rvalid_i = 1;
    chk("to_stray_rvalid", IDLE, 32'h0);
    dmem_rvalid_i = 0;
    chk("to_after", IDLE, 32'h0);

    // Reset while in MEM_RESP, then a stray rvalid
    mem_valid_i = 1; mem_read_i = 1; dmem_gnt_i = 1;
    chk("rst_ld_gnt", REQ_LD, 32'h0);
    dmem_gnt_i = 0;
    chk("rst_resp_wait", RSP_WT, 32'h0);
    rst_i = 1;
    chk("rst_mid_access", IDLE, 32'h0);
    rst_i = 0;
    idle();
    dmem_rvalid_i = 1;
    chk("rst_stray_rvalid", IDLE, 32'h0);
    dmem_rvalid_i = 0;
    chk("rst_quiet", IDLE, 32'h0);
    // A fresh access after reset is issued normally
    mem_valid_i = 1; mem_read_i = 1; dmem_gnt_i = 1;
    chk("rst_reissue", REQ_LD, 32'h0);
    idle();
    dmem_rvalid_i = 1;
    chk("rst_reissue_done", IDLE, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_pipe_ctrl.md
Name: rv32i_pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Produces per-stage stall and flush controls and the PC redirect from the EX-stage branch/jump resolution.
- Detects load-use hazards between ID and EX.
- Runs the single-outstanding data-memory request/grant/response handshake for the MEM stage, freezing the pipeline while an access is pending.

Parameters:
- TIMEOUT_CYCLES, 0, cycles to wait in MEM_REQ/MEM_RESP before aborting with bus_err_o; 0 disables the timeout.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_addr_i  in  5  ID rs1 index
- id_rs2_addr_i  in  5  ID rs2 index
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_valid_i  in  1  EX holds a valid instruction
- ex_rd_addr_i  in  5  EX destination index
- ex_mem_read_i  in  1  EX instruction is a load
- ex_branch_taken_i  in  1  EX resolved taken branch or jump
- ex_branch_target_i  in  32  EX redirect target
- mem_valid_i  in  1  MEM holds a valid instruction
- mem_read_i  in  1  MEM instruction is a load
- mem_write_i  in  1  MEM instruction is a store
- dmem_req_o  out  1  data-memory request
- dmem_we_o  out  1  request is a write
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- stall_if_o  out  1  hold PC and IF/ID
- stall_id_o  out  1  hold ID/EX inputs
- stall_ex_o  out  1  hold EX/MEM
- stall_mem_o  out  1  hold MEM/WB
- flush_id_o  out  1  squash IF/ID contents
- flush_ex_o  out  1  insert bubble into ID/EX
- redirect_valid_o  out  1  load PC with redirect_pc_o
- redirect_pc_o  out  32  redirect target
- bus_err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- FSM states: RUN, MEM_REQ, MEM_RESP. Reset state is RUN. All outputs are 0 during and after reset, and the timeout counter is cleared.
- mem_access = mem_valid_i & (mem_read_i | mem_write_i).
- In RUN:
  - dmem_req_o = mem_access and dmem_we_o = mem_write_i, both combinational.
  - gnt on a store: stay in RUN with no stall (zero-cycle store).
  - gnt on a load: go to MEM_RESP.
  - No gnt: go to MEM_REQ.
- In MEM_REQ:
  - Hold dmem_req_o and dmem_we_o stable.
  - On gnt: a store returns to RUN; a load goes to MEM_RESP.
- In MEM_RESP:
  - dmem_req_o = 0.
  - On dmem_rvalid_i, return to RUN; the stall releases in that same cycle so MEM/WB captures the data.
- mem_stall = (state==RUN & mem_access & ~gnt) | (state==MEM_REQ & ~gnt) | (state==MEM_RESP & ~rvalid).
  - mem_stall asserts all four stall outputs.
  - mem_stall forces flush_id_o, flush_ex_o and redirect_valid_o to 0; the branch in EX stays frozen and redirects when the stall releases.
- Load-use hazard:
  - Condition: id_valid_i & ex_valid_i & ex_mem_read_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
  - Response: stall_if_o=1, stall_id_o=1, flush_ex_o=1. One bubble is inserted; forwarding is handled outside this block.
- Taken branch (ex_branch_taken_i & ~mem_stall):
  - redirect_valid_o=1, redirect_pc_o=ex_branch_target_i, flush_id_o=1, flush_ex_o=1.
  - Overrides load-use: stall_if_o and stall_id_o are 0 and the ID instruction is squashed.
- redirect_pc_o = 0 whenever redirect_valid_o=0.
- Priority order: reset > mem_stall > branch > load-use > run.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each cycle in MEM_REQ/MEM_RESP and clears on any transition.
  - On reaching TIMEOUT_CYCLES: bus_err_o pulses for one cycle, dmem_req_o drops, FSM goes to RUN, and stalls release in that cycle.
- Unexpected dmem_rvalid_i in RUN (e.g. a response after reset mid-access, or after a timeout) is ignored.
- Any reset mid-access aborts the access immediately; no req is reissued unless MEM still holds an access.

Optional Feature:
- Macro: RV32I_PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_mem_stall_cnt_o, perf_lu_stall_cnt_o and perf_flush_cnt_o, each CNT_W wide.
  - They count cycles with mem_stall, load-use stall cycles, and redirects respectively.
  - They saturate at all-ones and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- rv32i_core_pkg gains the pipe_ctrl_state_e enum (RUN, MEM_REQ, MEM_RESP) and a stage_ctrl_t struct (stall, flush) for per-stage control bundles.
- One sub-module, rv32i_dmem_seq, holds the FSM, handshake and timeout.
- Hazard and priority logic stays in the top.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle of stall_if/stall_id=1 and flush_ex=1; the next cycle is clean. With rd=x0 -> no stall.
- Taken branch, target 0x0000_0100, coincident with a load-use hazard -> redirect_valid=1, redirect_pc=0x100, flush_id=flush_ex=1, stall_if=0.
- Load, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> dmem_req held for 4 cycles, all stalls high for 5 cycles, released in the rvalid cycle.
- Store granted immediately -> dmem_req=dmem_we=1 for 1 cycle and zero stall cycles.
- Branch taken in EX while a MEM load awaits rvalid -> no redirect until the rvalid cycle, then redirect_valid=1 once.
- TIMEOUT_CYCLES=4 with gnt never asserted -> bus_err pulses in the 4th cycle and FSM returns to RUN. Separately, assert rst_i mid-MEM_RESP, then a stray rvalid arrives -> the rvalid is ignored and all outputs stay 0.
